// File: rtl/r_type_pkg.sv
// Shared constants and state encoding for the R-type control sequencer.
package r_type_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_e;

  function automatic logic is_supported_funct(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_NOR) || (f == FN_SLT);
  endfunction

endpackage

// File: rtl/r_type_decoder.sv
// Combinational field split and legality check of a latched MIPS R-type word.
module r_type_decoder
  import r_type_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [5:0]  funct_o,
  output logic        legal_o,
  output logic        is_arith_o
);

  logic [5:0] opcode;
  logic [4:0] shamt;

  always_comb begin
    opcode     = instr_i[31:26];
    rs_o       = instr_i[25:21];
    rt_o       = instr_i[20:16];
    rd_o       = instr_i[15:11];
    shamt      = instr_i[10:6];
    funct_o    = instr_i[5:0];
    legal_o    = (opcode == OP_RTYPE) && (shamt == '0) && is_supported_funct(funct_o);
    is_arith_o = (funct_o == FN_ADD) || (funct_o == FN_SUB);
  end

endmodule

// File: rtl/r_type_sequencer.sv
// IDLE->DECODE->EXEC->WB control sequencer gating the R-type register-file write.
module r_type_sequencer
  import r_type_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  input  logic             alu_overflow,
  output logic [4:0]       rf_rs,
  output logic [4:0]       rf_rt,
  output logic [4:0]       rf_rd,
  output logic             rf_we,
  output logic [5:0]       funct,
  output logic [1:0]       alu_op,
  output logic             done,
  output logic             illegal,
  output logic             ovf_trap,
  output logic [CNT_W-1:0] retired
);

  state_e             state_q, state_d;
  logic [31:0]        instr_q;
  logic [4:0]         rs_q, rt_q, rd_q;
  logic [5:0]         funct_q;
  logic [1:0]         alu_op_q;
  logic [CNT_W-1:0]   retired_q;

  logic [4:0] dec_rs, dec_rt, dec_rd;
  logic [5:0] dec_funct;
  logic       dec_legal, dec_arith;
  logic       ovf_hit;

  r_type_decoder u_dec (
    .instr_i   (instr_q),
    .rs_o      (dec_rs),
    .rt_o      (dec_rt),
    .rd_o      (dec_rd),
    .funct_o   (dec_funct),
    .legal_o   (dec_legal),
    .is_arith_o(dec_arith)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (instr_valid) state_d = DECODE;
      DECODE:  state_d = dec_legal ? EXEC : IDLE;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      funct_q   <= '0;
      alu_op_q  <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && instr_valid) instr_q <= instr;
      // Read-side fields load on entry to EXEC so they are stable for the ALU settle cycle.
      if (state_q == DECODE && dec_legal) begin
        rs_q     <= dec_rs;
        rt_q     <= dec_rt;
        funct_q  <= dec_funct;
        alu_op_q <= ALUOP_RTYPE;
      end
      if (state_q == EXEC) rd_q <= dec_rd;
      if (state_q == WB) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Overflow is the live ALU flag during WB, so the write gate decodes state plus that input.
  always_comb begin
    ovf_hit     = alu_overflow && dec_arith;
    instr_ready = (state_q == IDLE);
    illegal     = (state_q == DECODE) && !dec_legal;
    done        = (state_q == WB);
    rf_we       = (state_q == WB) && (rd_q != '0) && !ovf_hit;
    ovf_trap    = (state_q == WB) && ovf_hit;
    rf_rs       = rs_q;
    rf_rt       = rt_q;
    rf_rd       = rd_q;
    funct       = funct_q;
    alu_op      = alu_op_q;
    retired     = retired_q;
  end

endmodule
